// File: rtl/reward_pkg.sv
// Shared constants for the reward manager: channel indices, reward type codes
// and the pickup handshake state encoding.
package reward_pkg;

    localparam int CH_INVINCIBLE = 0;
    localparam int CH_FASTER     = 1;
    localparam int CH_FROZEN     = 2;
    localparam int CH_LASER      = 3;

    localparam int TYPE_NONE       = 0;
    localparam int TYPE_INVINCIBLE = 1;
    localparam int TYPE_FASTER     = 2;
    localparam int TYPE_FROZEN     = 3;
    localparam int TYPE_LASER      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACK   = 2'd2
    } pickup_state_e;

endpackage

// File: rtl/reward_timer.sv
// One reward channel countdown: load to DURATION takes priority over a tick
// decrement; the active flag drops on the same edge remain reaches zero.
module reward_timer
    import reward_pkg::*;
#(
    parameter int TIMER_W  = 10,
    parameter int DURATION = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec_en,
    output logic               active,
    output logic [TIMER_W-1:0] remain
);

    logic [TIMER_W-1:0] remain_q, remain_d;
    logic               active_q, active_d;

    // Next-state: a load beats a same-cycle tick, so that tick is not counted.
    always_comb begin
        remain_d = remain_q;
        active_d = active_q;
        if (load) begin
            remain_d = TIMER_W'(DURATION);
            active_d = 1'b1;
        end else if (dec_en && active_q) begin
            remain_d = remain_q - TIMER_W'(1);
            active_d = (remain_q != TIMER_W'(1));
        end else begin
            remain_d = remain_q;
            active_d = active_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remain_q <= '0;
            active_q <= 1'b0;
        end else begin
            remain_q <= remain_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign remain = remain_q;

endmodule

// File: rtl/reward_manager.sv
// Power-up manager: pickup handshake with the reward generator plus one
// independent countdown per channel. REWARD_FORCE_SW_EN adds the force_sw debug port.
module reward_manager
    import reward_pkg::*;
#(
    parameter int NUM_REWARDS = 4,
    parameter int POS_W       = 5,
    parameter int TIMER_W     = 10,
    parameter int DURATION    = 30,
    parameter int TYPE_W      = $clog2(NUM_REWARDS + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick,
    input  logic                           enable,
    input  logic                           mode_classic,
    input  logic                           mode_infinity,
    input  logic [POS_W-1:0]               tank_xpos,
    input  logic [POS_W-1:0]               tank_ypos,
    input  logic                           spawn_valid,
    input  logic [TYPE_W-1:0]              spawn_type,
    input  logic [POS_W-1:0]               spawn_xpos,
    input  logic [POS_W-1:0]               spawn_ypos,
`ifdef REWARD_FORCE_SW_EN
    input  logic [NUM_REWARDS-1:0]         force_sw,
`endif
    output logic                           spawn_ack,
    output logic [NUM_REWARDS-1:0]         reward_active,
    output logic [NUM_REWARDS*TIMER_W-1:0] reward_remain,
    output logic                           pickup_pulse,
    output logic [TYPE_W-1:0]              pickup_type,
    output logic                           addtime_pulse
);

    pickup_state_e          state_q;
    logic                   pickup_pulse_q, addtime_pulse_q;
    logic [TYPE_W-1:0]      pickup_type_q;
    logic                   match_s, pickup_s, addtime_s, dec_en_s;
    logic [NUM_REWARDS-1:0] load_s;
    logic                   unused_mode_s;

    // Classic is simply "not infinity"; the input is kept for the game interface.
    assign unused_mode_s = mode_classic;

    // Pickup detection and per-channel load decode.
    always_comb begin
        match_s   = (tank_xpos == spawn_xpos) && (tank_ypos == spawn_ypos);
        pickup_s  = enable && (state_q == ARMED) && spawn_valid && match_s;
        addtime_s = pickup_s && mode_infinity && (spawn_type == TYPE_W'(TYPE_INVINCIBLE));
        dec_en_s  = enable && tick;
        load_s    = '0;
        for (int i = 0; i < NUM_REWARDS; i++) begin
            if (pickup_s && (spawn_type == TYPE_W'(i + 1))
                && !((i == CH_INVINCIBLE) && mode_infinity)) begin
                load_s[i] = 1'b1;
            end else begin
                load_s[i] = 1'b0;
            end
        end
`ifdef REWARD_FORCE_SW_EN
        load_s = load_s | (force_sw & {NUM_REWARDS{dec_en_s}});
`endif
    end

    // Pickup handshake FSM with registered event outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pickup_pulse_q  <= 1'b0;
            addtime_pulse_q <= 1'b0;
            pickup_type_q   <= '0;
        end else begin
            pickup_pulse_q  <= pickup_s;
            addtime_pulse_q <= addtime_s;
            if (pickup_s) begin
                pickup_type_q <= spawn_type;
            end else begin
                pickup_type_q <= pickup_type_q;
            end
            if (!enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:    state_q <= spawn_valid ? ARMED : IDLE;
                    ARMED:   state_q <= !spawn_valid ? IDLE : (match_s ? ACK : ARMED);
                    ACK:     state_q <= spawn_valid ? ACK : IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign spawn_ack     = (state_q == ACK);
    assign pickup_pulse  = pickup_pulse_q;
    assign addtime_pulse = addtime_pulse_q;
    assign pickup_type   = pickup_type_q;

    for (genvar g = 0; g < NUM_REWARDS; g++) begin : g_timer
        reward_timer #(
            .TIMER_W  (TIMER_W),
            .DURATION (DURATION)
        ) u_timer (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load_s[g]),
            .dec_en (dec_en_s),
            .active (reward_active[g]),
            .remain (reward_remain[g*TIMER_W +: TIMER_W])
        );
    end

endmodule

// File: tb/tb_reward_manager.sv
// Scoreboard bench for reward_manager: driver advances a behavioural model and
// queues expected outputs; a monitor compares them one cycle later.
module tb_reward_manager;
    localparam int NR  = 4;
    localparam int PW  = 5;
    localparam int TW  = 10;
    localparam int DUR = 30;
    localparam int YW  = 3;

    logic clk = 1'b0;
    logic rst_n, tick, enable, mode_classic, mode_infinity, spawn_valid;
    logic [PW-1:0] tank_xpos, tank_ypos, spawn_xpos, spawn_ypos;
    logic [YW-1:0] spawn_type;
    logic [NR-1:0] force_sw;
    logic spawn_ack, pickup_pulse, addtime_pulse;
    logic [NR-1:0] reward_active;
    logic [NR*TW-1:0] reward_remain;
    logic [YW-1:0] pickup_type;

    always #5 clk = ~clk;

    reward_manager #(.NUM_REWARDS(NR), .POS_W(PW), .TIMER_W(TW), .DURATION(DUR)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .mode_classic(mode_classic), .mode_infinity(mode_infinity),
        .tank_xpos(tank_xpos), .tank_ypos(tank_ypos),
        .spawn_valid(spawn_valid), .spawn_type(spawn_type),
        .spawn_xpos(spawn_xpos), .spawn_ypos(spawn_ypos),
`ifdef REWARD_FORCE_SW_EN
        .force_sw(force_sw),
`endif
        .spawn_ack(spawn_ack), .reward_active(reward_active),
        .reward_remain(reward_remain), .pickup_pulse(pickup_pulse),
        .pickup_type(pickup_type), .addtime_pulse(addtime_pulse)
    );

    typedef struct packed {
        logic          ack;
        logic [NR-1:0] act;
        logic [NR*TW-1:0] rem;
        logic          pp;
        logic [YW-1:0] pt;
        logic          at;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Model state: handshake phase and remaining ticks per channel.
    bit m_armed, m_ack, m_pp, m_at;
    int m_pt;
    int m_rem[NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [NR-1:0] ld;
        exp_t e;
        ld = '0;
        if (!rst_n) begin
            m_armed = 0; m_ack = 0; m_pp = 0; m_at = 0; m_pt = 0;
            for (int i = 0; i < NR; i++) m_rem[i] = 0;
        end else begin
            m_pp = 0; m_at = 0;
            if (!enable) begin
                m_armed = 0; m_ack = 0;
            end else if (m_ack) begin
                if (!spawn_valid) m_ack = 0;
            end else if (m_armed) begin
                if (!spawn_valid) m_armed = 0;
                else if (tank_xpos == spawn_xpos && tank_ypos == spawn_ypos) begin
                    m_armed = 0; m_ack = 1; m_pp = 1; m_pt = int'(spawn_type);
                    if (m_pt == 1 && mode_infinity) m_at = 1;
                    else if (m_pt >= 1 && m_pt <= NR) ld[m_pt-1] = 1'b1;
                end
            end else if (spawn_valid) m_armed = 1;
`ifdef REWARD_FORCE_SW_EN
            if (enable && tick) ld = ld | force_sw;
`endif
            for (int i = 0; i < NR; i++) begin
                if (ld[i]) m_rem[i] = DUR;
                else if (enable && tick && m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
            end
        end
        e.ack = m_ack; e.pp = m_pp; e.at = m_at; e.pt = YW'(m_pt);
        for (int i = 0; i < NR; i++) begin
            e.act[i] = (m_rem[i] > 0);
            e.rem[i*TW +: TW] = TW'(m_rem[i]);
        end
        exp_q.push_back(e);
    endtask

    // Inputs are set at a negedge; record expectation then advance one cycle.
    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; idle_cycles(2);
        end
    endtask

    task automatic pickup(input int t);
        spawn_xpos = tank_xpos; spawn_ypos = tank_ypos;
        spawn_type = YW'(t); spawn_valid = 1'b1;
        idle_cycles(3);
        spawn_valid = 1'b0;
        idle_cycles(2);
    endtask

    // Monitor: compare each registered output snapshot after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("spawn_ack", 64'(spawn_ack), 64'(e.ack));
                check("reward_active", 64'(reward_active), 64'(e.act));
                check("reward_remain", 64'(reward_remain), 64'(e.rem));
                check("pickup_pulse", 64'(pickup_pulse), 64'(e.pp));
                check("pickup_type", 64'(pickup_type), 64'(e.pt));
                check("addtime_pulse", 64'(addtime_pulse), 64'(e.at));
            end
        end
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; enable = 1'b0; mode_classic = 1'b1; mode_infinity = 1'b0;
        spawn_valid = 1'b0; spawn_type = '0; force_sw = '0;
        tank_xpos = 5'd4; tank_ypos = 5'd7; spawn_xpos = 5'd4; spawn_ypos = 5'd7;
        @(negedge clk);
        idle_cycles(3);
        rst_n = 1'b1; enable = 1'b1;
        idle_cycles(2);

        // Type 3 at (4,7) loads ch2, then 30 ticks expire it.
        pickup(3);
        do_ticks(30);
        idle_cycles(2);

        // Refresh ch1 after 10 ticks.
        pickup(2);
        do_ticks(10);
        pickup(2);
        do_ticks(3);

        // Type 1 in infinity mode, then in classic mode.
        mode_infinity = 1'b1; mode_classic = 1'b0;
        pickup(1);
        mode_infinity = 1'b0; mode_classic = 1'b1;
        pickup(1);

        // Pickup coinciding with a tick on ch3, overlapping ch0, then a freeze.
        spawn_type = 3'd4; spawn_valid = 1'b1;
        cycle();
        tick = 1'b1; cycle();
        tick = 1'b0; spawn_valid = 1'b0; idle_cycles(2);
        do_ticks(5);
        enable = 1'b0;
        do_ticks(5);
        enable = 1'b1;
        do_ticks(32);

        // Out-of-range type acknowledged without effect.
        pickup(7);

`ifdef REWARD_FORCE_SW_EN
        force_sw = 4'b1000;
        do_ticks(40);
        force_sw = 4'b0000;
        pickup(7);
        do_ticks(31);
`endif

        // Reset mid-ACK.
        spawn_type = 3'd2; spawn_valid = 1'b1;
        idle_cycles(3);
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; spawn_valid = 1'b0; idle_cycles(2);

        // Randomised traffic with a tiny coordinate space to provoke matches.
        for (int i = 0; i < 4000; i++) begin
            rst_n         = ($urandom_range(0, 599) != 0);
            enable        = ($urandom_range(0, 19) != 0);
            tick          = ($urandom_range(0, 3) == 0);
            mode_infinity = $urandom_range(0, 1) == 1;
            mode_classic  = !mode_infinity;
            if ($urandom_range(0, 7) == 0) spawn_valid = !spawn_valid;
            spawn_type    = YW'($urandom_range(0, 7));
            tank_xpos     = PW'($urandom_range(0, 1));
            tank_ypos     = PW'($urandom_range(0, 1));
            spawn_xpos    = PW'($urandom_range(0, 1));
            spawn_ypos    = PW'($urandom_range(0, 1));
`ifdef REWARD_FORCE_SW_EN
            force_sw      = ($urandom_range(0, 9) == 0) ? NR'($urandom) : '0;
`endif
            cycle();
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
